// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg -- definitions shared by the UART transmitter and receiver.
//
// Contents:
//   tx_state_t   : frame state enum (IDLE, START, DATA, PARITY, STOP)
//   PARITY_EVEN  : parity select value, XOR of the data bits
//   PARITY_ODD   : parity select value, inverse XOR of the data bits
//   data_mask()  : mask keeping the low nbits of a byte
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int PARITY_EVEN = 0;
    localparam int PARITY_ODD  = 1;

    function automatic logic [7:0] data_mask(input int nbits);
        data_mask = 8'((9'd1 << nbits) - 9'd1);
    endfunction

endpackage

// File: rtl/baud_gen.sv
// ---------------------------------------------------------------------------
// baud_gen -- bit-period timer for the UART transmitter.
//
// A 32-bit counter runs 0 .. DIVISOR-1 and wraps; tick is high for the one
// cycle in which the count equals DIVISOR-1, i.e. the last cycle of a bit.
//
// Parameters:
//   DIVISOR : clk cycles per bit period (2 .. 2^32-1)
// Ports:
//   clk   : clock, rising edge
//   RSTn  : asynchronous active-low reset, clears the count
//   clear : synchronous clear, holds the count at 0
//   tick  : last cycle of the current bit period
// ---------------------------------------------------------------------------
module baud_gen #(
    parameter int unsigned DIVISOR = 10
) (
    input  logic clk,
    input  logic RSTn,
    input  logic clear,
    output logic tick
);

    localparam logic [31:0] LAST = 32'(DIVISOR - 1);

    logic [31:0] count;

    assign tick = (count == LAST);

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/tx_fsm.sv
// ---------------------------------------------------------------------------
// tx_fsm -- UART transmitter.
//
// Sends start bit (0), TX_NUM_BITS data bits LSB first, an optional parity
// bit, and one stop bit (1). Each bit lasts DIVISOR clk cycles.
//
// Build option:
//   TX_PARITY_EN : when defined, a parity bit follows the data bits
//                  (even or odd as chosen by PARITY); when undefined the
//                  frame goes straight from data to stop.
//
// Parameters:
//   DIVISOR     : clk cycles per bit (2 .. 2^32-1)
//   TX_NUM_BITS : data bits per frame (5 .. 8)
//   PARITY      : PARITY_EVEN (0) or PARITY_ODD (1)
// Ports:
//   clk       : clock, rising edge
//   RSTn      : asynchronous active-low reset; aborts any frame
//   data_in   : byte to send; bits above TX_NUM_BITS-1 are ignored
//   tx_valid  : data_in is valid
//   tx_ready  : transmitter idle, can accept a byte
//   TX        : serial line, registered, idle high
//   tx_busy   : frame in progress (inverse of tx_ready)
//   tx_done   : one-cycle pulse as the stop bit completes
//   state_dbg : current FSM state
//
// Handshake: a byte is taken on a rising clk edge where tx_valid and
// tx_ready are both 1; tx_ready is 1 exactly while in IDLE, so tx_valid
// and data_in are don't-care for the whole frame.
// ---------------------------------------------------------------------------
module tx_fsm #(
    parameter int unsigned DIVISOR     = 10,
    parameter int          TX_NUM_BITS = 8,
    parameter int          PARITY      = 0
) (
    input  logic                clk,
    input  logic                RSTn,
    input  logic [7:0]          data_in,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic                TX,
    output logic                tx_busy,
    output logic                tx_done,
    output uart_pkg::tx_state_t state_dbg
);

    import uart_pkg::*;

    // PARITY names the module parameter here, so the parity state is
    // always written with its package prefix.

    localparam logic [3:0] LAST_BIT  = 4'(TX_NUM_BITS - 1);
    localparam logic [7:0] DATA_MASK = data_mask(TX_NUM_BITS);

    if (TX_NUM_BITS < 5 || TX_NUM_BITS > 8) begin : g_bad_num_bits
        $error("tx_fsm: TX_NUM_BITS must be 5..8");
    end
    if (PARITY != PARITY_EVEN && PARITY != PARITY_ODD) begin : g_bad_parity
        $error("tx_fsm: PARITY must be 0 or 1");
    end
    if (DIVISOR < 2) begin : g_bad_divisor
        $error("tx_fsm: DIVISOR must be at least 2");
    end

    tx_state_t  state, state_n;
    logic [3:0] bit_cnt, bit_cnt_n;
    logic [7:0] data_reg, data_n;
    logic       tx_n;
    logic       done_n;
    logic       tick;

    // The baud counter sits at 0 throughout IDLE, so the acceptance edge
    // starts the start bit with a fresh count.
    baud_gen #(
        .DIVISOR (DIVISOR)
    ) u_baud (
        .clk   (clk),
        .RSTn  (RSTn),
        .clear (state == IDLE),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            data_reg <= '0;
            TX       <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            data_reg <= data_n;
            TX       <= tx_n;
            tx_done  <= done_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        data_n    = data_reg;
        done_n    = 1'b0;
        case (state)
            IDLE: begin
                if (tx_valid) begin
                    state_n   = START;
                    bit_cnt_n = '0;
                    data_n    = data_in & DATA_MASK;
                end
            end
            START: begin
                if (tick) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt == LAST_BIT) begin
`ifdef TX_PARITY_EN
                        state_n = uart_pkg::PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end
                end
            end
            uart_pkg::PARITY: begin
`ifdef TX_PARITY_EN
                if (tick) begin
                    state_n = STOP;
                end
`else
                // Unreachable without the parity slot; recover to IDLE.
                state_n = IDLE;
`endif
            end
            STOP: begin
                if (tick) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // TX is registered from the next state, so the line changes on the
    // same edge as the state and each bit spans exactly one bit period.
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            START: tx_n = 1'b0;
            DATA:  tx_n = data_n[bit_cnt_n[2:0]];
`ifdef TX_PARITY_EN
            uart_pkg::PARITY: tx_n = (^data_n) ^ (PARITY == PARITY_ODD);
`endif
            default: tx_n = 1'b1;
        endcase
    end

    assign tx_ready  = (state == IDLE);
    assign tx_busy   = ~tx_ready;
    assign state_dbg = state;

endmodule
